hbridge_gate_sequencer: RTL and testbench
=========================================

# hbridge_gate_sequencer

- Sits directly downstream of the PWM controller.
- Inputs: the PWM waveform, the FWD/REV direction outputs and the enable.
- Outputs: the four H-bridge gate signals, with programmable dead-time insertion, a mandatory coast interval before any direction reversal, and a latched overcurrent shutdown.
- Guarantees that no half-bridge ever sees both gates on in the same cycle.

## Interface
- DEAD_CYCLES, 4: dead time in clk_i cycles between opposing gates of one leg; legal range 1..255.
- REVERSE_WAIT, 1000: all-off coast duration in cycles before returning to STOP; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of the coast counter.
- clk_i  in  1  clock.
- reset_l  in  1  reset, asynchronous, active-low.
- pwm_i  in  1  PWM waveform from the PWM controller; asynchronous to the gate logic.
- dir_fwd_i  in  1  forward request.
- dir_rev_i  in  1  reverse request.
- enable_i  in  1  drive enable.
- fault_i  in  1  overcurrent, active-high, asynchronous.
- fault_clr_i  in  1  clears the latched fault; level-sampled.
- gate_ah_o  out  1  leg A high-side gate.
- gate_al_o  out  1  leg A low-side gate.
- gate_bh_o  out  1  leg B high-side gate.
- gate_bl_o  out  1  leg B low-side gate.
- state_o  out  3  current state.
- fault_o  out  1  latched fault flag.

## Operation
- **Synchronisation:** pwm_i, dir_fwd_i, dir_rev_i, enable_i, fault_i and fault_clr_i each pass through a 2-flop synchronizer. The synchronized versions carry the suffix _s.
- **Direction decode:**
  - fwd_req = dir_fwd_s & ~dir_rev_s & enable_s.
  - rev_req = dir_rev_s & ~dir_fwd_s & enable_s.
  - Both or neither requested = no request.
- **States** (state_o encoding): STOP=0, DRIVE_FWD=1, DRIVE_REV=2, COAST=3, FAULT=4.
- **STOP:** all gates 0. fwd_req -> DRIVE_FWD; rev_req -> DRIVE_REV.
- **DRIVE_FWD:**
  - gate_bl_o static on; gate_bh_o off.
  - Leg A switches: gate_ah_o follows pwm_s, gate_al_o follows ~pwm_s, both with dead time.
  - Loss of fwd_req (including enable drop or a both-asserted request) -> COAST.
- **DRIVE_REV:** mirror of DRIVE_FWD.
  - gate_al_o static on; gate_ah_o off.
  - Leg B switches on pwm_s.
  - Loss of rev_req -> COAST.
- **Drive entry:** the dead counter clears and all gates stay 0 for DEAD_CYCLES cycles. After that the static low-side gate and the switching gate matching pwm_s assert.
- **Dead time (switching leg):**
  - Every pwm_s edge clears the dead counter and deasserts both gates of the leg.
  - Once the counter reaches DEAD_CYCLES, the gate matching the pwm_s level asserts.
  - A pwm_s level lasting fewer than DEAD_CYCLES cycles never asserts its gate. The pulse is swallowed.
- **COAST:**
  - All gates 0; the coast counter loads REVERSE_WAIT on entry and decrements.
  - At 0 -> STOP.
  - Requests are ignored in COAST.
- **FAULT:**
  - Entered from any state when fault_s = 1. All gates 0; fault_o = 1.
  - Exits to STOP only when fault_clr_s = 1 and fault_s = 0 in the same cycle.
  - fault_clr_s while fault_s is still 1 is ignored.
- **Priority:** fault > state transition > gate update. If fault_s rises in the same cycle as a direction change, FAULT wins.
- **Invariants** (every cycle, including reset release and transitions):
  - ~(gate_ah_o & gate_al_o)
  - ~(gate_bh_o & gate_bl_o)
  - no high-side on in COAST, STOP or FAULT.
- **Reset:** all gates 0, state_o = 0 (STOP), fault_o = 0, counters 0, synchronizers 0. Reset mid-drive forces gates 0 asynchronously.

## Timing
- All outputs are registered. Counts below are from the input-change edge; "pwm change" means the change of the PWM input pwm_i.
- pwm change -> opposing gate deasserts: 3 cycles (2 sync + 1 reg).
- pwm change -> matching gate asserts: 3 + DEAD_CYCLES cycles.
- fault_i -> all gates 0 and fault_o = 1: 3 cycles.
- Direction or enable drop -> all gates 0: 3 cycles.
- Direction reversal, from request change to the first new-direction gate: 3 (sync+reg, COAST entry) + REVERSE_WAIT (COAST) + 1 (STOP) + 1 (DRIVE entry) + DEAD_CYCLES cycles.
- A full reversal never passes through a cycle with any high-side gate on during COAST.

## Test plan
All scenarios use DEAD_CYCLES=4, REVERSE_WAIT=20.

1. **Forward drive.** Stimulus: enable=1, fwd=1, then pwm_i toggles with period 40, 50% duty. Required response:
   - state_o = 1 and gate_bl_o = 1.
   - gate_al_o falls 3 cycles after each pwm_i rise; gate_ah_o rises 7 cycles after.
   - gate_bh_o = 0 throughout.
2. **Pulse swallowing.** Stimulus: in DRIVE_FWD, a 3-cycle pwm_i high pulse. Required response: gate_ah_o stays 0; gate_al_o drops for the pulse plus dead time, then returns to 1.
3. **Reversal.** Stimulus: fwd -> rev switch at cycle T. Required response:
   - Gates all 0 from T+3.
   - state_o = 3 for 20 cycles, then 0, then 2.
   - gate_al_o = 1 no earlier than T+3+20+1+1+4.
   - No high-side gate on during COAST.
4. **Fault.** Stimulus: fault_i pulse mid-drive, then fault_clr_i asserted while fault_i = 1, then again after fault_i = 0. Required response:
   - Gates 0 and fault_o = 1 at +3 cycles.
   - The first clear is ignored; the second returns state_o to 0 and fault_o to 0.
5. **Illegal request.** Stimulus: fwd=rev=1 in DRIVE_REV. Required response: COAST, then STOP; state stays STOP while both remain asserted.
6. **Reset mid-drive.** Stimulus: reset_l asserted while gate_ah_o = 1. Required response:
   - All outputs 0 immediately (asynchronous).
   - After release, state_o = 0 and gates stay 0 until a request has been synchronized.
   - Bench asserts both shoot-through invariants every cycle across all scenarios.

Source files
------------

// File: rtl/hbridge_gate_sequencer.sv
// H-bridge gate sequencer: turns PWM plus a direction request into four gate drives, with dead time,
// a coast interval before any reversal, and a latched overcurrent shutdown.
module hbridge_gate_sequencer #(
   parameter int unsigned DEAD_CYCLES  = 4,
   parameter int unsigned REVERSE_WAIT = 1000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk_i,
   input  logic       reset_l,
   input  logic       pwm_i,
   input  logic       dir_fwd_i,
   input  logic       dir_rev_i,
   input  logic       enable_i,
   input  logic       fault_i,
   input  logic       fault_clr_i,
   output logic       gate_ah_o,
   output logic       gate_al_o,
   output logic       gate_bh_o,
   output logic       gate_bl_o,
   output logic [2:0] state_o,
   output logic       fault_o
);

   typedef enum logic [2:0] {
      STOP      = 3'd0,
      DRIVE_FWD = 3'd1,
      DRIVE_REV = 3'd2,
      COAST     = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam logic [7:0]       DEAD_M1    = 8'(DEAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] COAST_LOAD = CNT_W'(REVERSE_WAIT);

   state_t           state;
   logic [5:0]       sync_a, sync_b;
   logic             pwm_s, dir_fwd_s, dir_rev_s, enable_s, fault_s, fault_clr_s;
   logic             pwm_d;
   logic             settle;
   logic [7:0]       dead_cnt, dead_cnt_nxt;
   logic [CNT_W-1:0] coast_cnt;
   logic             fwd_req, rev_req, pwm_edge, dead_done;

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {fault_clr_i, fault_i, enable_i, dir_rev_i, dir_fwd_i, pwm_i};
         sync_b <= sync_a;
      end
   end

   assign pwm_s       = sync_b[0];
   assign dir_fwd_s   = sync_b[1];
   assign dir_rev_s   = sync_b[2];
   assign enable_s    = sync_b[3];
   assign fault_s     = sync_b[4];
   assign fault_clr_s = sync_b[5];

   assign state_o = state;

   // settle holds the dead counter at zero for one extra cycle on drive entry,
   // so a fresh drive never asserts gates earlier than a pwm edge would allow.
   always_comb begin
      fwd_req   = dir_fwd_s & ~dir_rev_s & enable_s;
      rev_req   = dir_rev_s & ~dir_fwd_s & enable_s;
      pwm_edge  = pwm_s ^ pwm_d;
      dead_done = ~settle & ~pwm_edge & (dead_cnt >= DEAD_M1);
      if (settle || pwm_edge)
         dead_cnt_nxt = '0;
      else if (dead_cnt < DEAD_M1)
         dead_cnt_nxt = dead_cnt + 8'd1;
      else
         dead_cnt_nxt = dead_cnt;
   end

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         state     <= STOP;
         gate_ah_o <= 1'b0;
         gate_al_o <= 1'b0;
         gate_bh_o <= 1'b0;
         gate_bl_o <= 1'b0;
         fault_o   <= 1'b0;
         pwm_d     <= 1'b0;
         settle    <= 1'b0;
         dead_cnt  <= '0;
         coast_cnt <= '0;
      end else begin
         pwm_d <= pwm_s;
         if (fault_s) begin
            state     <= FAULT;
            gate_ah_o <= 1'b0;
            gate_al_o <= 1'b0;
            gate_bh_o <= 1'b0;
            gate_bl_o <= 1'b0;
            fault_o   <= 1'b1;
            settle    <= 1'b0;
            dead_cnt  <= '0;
            coast_cnt <= '0;
         end else begin
            case (state)
               STOP: begin
                  gate_ah_o <= 1'b0;
                  gate_al_o <= 1'b0;
                  gate_bh_o <= 1'b0;
                  gate_bl_o <= 1'b0;
                  dead_cnt  <= '0;
                  if (fwd_req) begin
                     state  <= DRIVE_FWD;
                     settle <= 1'b1;
                  end else if (rev_req) begin
                     state  <= DRIVE_REV;
                     settle <= 1'b1;
                  end
               end
               DRIVE_FWD: begin
                  if (!fwd_req) begin
                     state     <= COAST;
                     coast_cnt <= COAST_LOAD;
                     gate_ah_o <= 1'b0;
                     gate_al_o <= 1'b0;
                     gate_bh_o <= 1'b0;
                     gate_bl_o <= 1'b0;
                     dead_cnt  <= '0;
                     settle    <= 1'b0;
                  end else begin
                     settle    <= 1'b0;
                     dead_cnt  <= dead_cnt_nxt;
                     gate_ah_o <= dead_done & pwm_s;
                     gate_al_o <= dead_done & ~pwm_s;
                     gate_bh_o <= 1'b0;
                     gate_bl_o <= gate_bl_o | dead_done;
                  end
               end
               DRIVE_REV: begin
                  if (!rev_req) begin
                     state     <= COAST;
                     coast_cnt <= COAST_LOAD;
                     gate_ah_o <= 1'b0;
                     gate_al_o <= 1'b0;
                     gate_bh_o <= 1'b0;
                     gate_bl_o <= 1'b0;
                     dead_cnt  <= '0;
                     settle    <= 1'b0;
                  end else begin
                     settle    <= 1'b0;
                     dead_cnt  <= dead_cnt_nxt;
                     gate_bh_o <= dead_done & pwm_s;
                     gate_bl_o <= dead_done & ~pwm_s;
                     gate_ah_o <= 1'b0;
                     gate_al_o <= gate_al_o | dead_done;
                  end
               end
               COAST: begin
                  gate_ah_o <= 1'b0;
                  gate_al_o <= 1'b0;
                  gate_bh_o <= 1'b0;
                  gate_bl_o <= 1'b0;
                  dead_cnt  <= '0;
                  // Leave on the last counted cycle so COAST lasts exactly REVERSE_WAIT cycles.
                  if (coast_cnt == CNT_W'(1) || coast_cnt == '0) begin
                     state     <= STOP;
                     coast_cnt <= '0;
                  end else begin
                     coast_cnt <= coast_cnt - 1'b1;
                  end
               end
               FAULT: begin
                  gate_ah_o <= 1'b0;
                  gate_al_o <= 1'b0;
                  gate_bh_o <= 1'b0;
                  gate_bl_o <= 1'b0;
                  dead_cnt  <= '0;
                  if (fault_clr_s) begin
                     state   <= STOP;
                     fault_o <= 1'b0;
                  end
               end
               default: begin
                  state     <= STOP;
                  gate_ah_o <= 1'b0;
                  gate_al_o <= 1'b0;
                  gate_bh_o <= 1'b0;
                  gate_bl_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// Scoreboard bench for hbridge_gate_sequencer: stimulus queues cycle-stamped expected outputs,
// a monitor compares them and the shoot-through invariants on every falling clock edge.
module tb_hbridge_gate_sequencer;

   logic       clk_i = 1'b0;
   logic       reset_l = 1'b0;
   logic       pwm_i = 1'b0;
   logic       dir_fwd_i = 1'b0;
   logic       dir_rev_i = 1'b0;
   logic       enable_i = 1'b0;
   logic       fault_i = 1'b0;
   logic       fault_clr_i = 1'b0;
   logic       gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o, fault_o;
   logic [2:0] state_o;

   typedef struct {
      int         cyc;
      string      name;
      logic [7:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   stim_done = 1'b0;
   int   done_cyc = 0;

   hbridge_gate_sequencer #(
      .DEAD_CYCLES (4),
      .REVERSE_WAIT(20),
      .CNT_W       (16)
   ) dut (
      .clk_i      (clk_i),
      .reset_l    (reset_l),
      .pwm_i      (pwm_i),
      .dir_fwd_i  (dir_fwd_i),
      .dir_rev_i  (dir_rev_i),
      .enable_i   (enable_i),
      .fault_i    (fault_i),
      .fault_clr_i(fault_clr_i),
      .gate_ah_o  (gate_ah_o),
      .gate_al_o  (gate_al_o),
      .gate_bh_o  (gate_bh_o),
      .gate_bl_o  (gate_bl_o),
      .state_o    (state_o),
      .fault_o    (fault_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // gates = {ah, al, bh, bl}
   function automatic logic [7:0] pk(input logic [3:0] gates, input logic [2:0] st, input logic f);
      return {gates, st, f};
   endfunction

   function automatic logic [7:0] outs();
      return {gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o, state_o, fault_o};
   endfunction

   task automatic expect_at(input int c, input string name, input logic [7:0] v);
      exp_t e;
      e.cyc  = c;
      e.name = name;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic wait_edge();
      @(posedge clk_i);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) wait_edge();
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
      n_total++;
      if (got === req) n_pass++;
      else $display("FAIL %s (cycle %0d): got %b required %b", name, cyc, got, req);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   // Monitor: the only process that updates the pass/total counters.
   initial begin
      forever begin
         @(negedge clk_i or negedge reset_l);
         if (!reset_l) begin
            #1;
            check("reset_outputs_zero", outs(), 8'h00);
         end else begin
            check("inv_leg_a", {7'b0, gate_ah_o & gate_al_o}, 8'h00);
            check("inv_leg_b", {7'b0, gate_bh_o & gate_bl_o}, 8'h00);
            check("inv_high_side_idle",
                  {7'b0, (state_o == 3'd0 || state_o == 3'd3 || state_o == 3'd4) & (gate_ah_o | gate_bh_o)},
                  8'h00);
            while (q.size() != 0 && q[0].cyc <= cyc) begin
               if (q[0].cyc == cyc) begin
                  check(q[0].name, outs(), q[0].val);
               end else begin
                  n_total++;
                  $display("FAIL %s: sample at cycle %0d missed, required %b", q[0].name, q[0].cyc, q[0].val);
               end
               void'(q.pop_front());
            end
         end
         if (stim_done && q.size() == 0) finish_run();
         if ((stim_done && cyc > done_cyc + 50) || cyc > 20000) begin
            n_total++;
            $display("FAIL timeout: %0d expectations still pending, required 0", q.size());
            finish_run();
         end
      end
   end

   initial begin
      int t, r, f, p, x, y;
      step(3);
      reset_l = 1'b1;
      t = cyc;
      expect_at(t,     "reset_state",  pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 2, "reset_idle",   pk(4'b0000, 3'd0, 1'b0));

      // Forward drive: entry, then two PWM periods of 40.
      wait_edge();
      t = cyc;
      enable_i = 1'b1; dir_fwd_i = 1'b1;
      expect_at(t + 2, "fwd_not_yet",  pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 3, "fwd_entry",    pk(4'b0000, 3'd1, 1'b0));
      expect_at(t + 7, "fwd_entry_dt", pk(4'b0000, 3'd1, 1'b0));
      expect_at(t + 8, "fwd_gates_on", pk(4'b0101, 3'd1, 1'b0));
      step(10);
      for (int i = 0; i < 2; i++) begin
         r = cyc;
         pwm_i = 1'b1;
         expect_at(r + 2, "rise_al_held", pk(4'b0101, 3'd1, 1'b0));
         expect_at(r + 3, "rise_al_off",  pk(4'b0001, 3'd1, 1'b0));
         expect_at(r + 6, "rise_dead",    pk(4'b0001, 3'd1, 1'b0));
         expect_at(r + 7, "rise_ah_on",   pk(4'b1001, 3'd1, 1'b0));
         step(20);
         f = cyc;
         pwm_i = 1'b0;
         expect_at(f + 2, "fall_ah_held", pk(4'b1001, 3'd1, 1'b0));
         expect_at(f + 3, "fall_ah_off",  pk(4'b0001, 3'd1, 1'b0));
         expect_at(f + 6, "fall_dead",    pk(4'b0001, 3'd1, 1'b0));
         expect_at(f + 7, "fall_al_on",   pk(4'b0101, 3'd1, 1'b0));
         step(20);
      end

      // Pulse swallowing: 3-cycle high pulse shorter than the dead time.
      p = cyc;
      pwm_i = 1'b1;
      expect_at(p + 3,  "pulse_al_off", pk(4'b0001, 3'd1, 1'b0));
      expect_at(p + 4,  "pulse_no_ah1", pk(4'b0001, 3'd1, 1'b0));
      expect_at(p + 6,  "pulse_no_ah2", pk(4'b0001, 3'd1, 1'b0));
      expect_at(p + 9,  "pulse_dead",   pk(4'b0001, 3'd1, 1'b0));
      expect_at(p + 10, "pulse_al_on",  pk(4'b0101, 3'd1, 1'b0));
      step(3);
      pwm_i = 1'b0;
      step(15);

      // Reversal fwd -> rev with pwm low, then leg B switching.
      t = cyc;
      dir_fwd_i = 1'b0; dir_rev_i = 1'b1;
      expect_at(t + 2,  "rev_still_fwd",  pk(4'b0101, 3'd1, 1'b0));
      expect_at(t + 3,  "rev_coast",      pk(4'b0000, 3'd3, 1'b0));
      expect_at(t + 12, "rev_coast_mid",  pk(4'b0000, 3'd3, 1'b0));
      expect_at(t + 22, "rev_coast_last", pk(4'b0000, 3'd3, 1'b0));
      expect_at(t + 23, "rev_stop",       pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 24, "rev_entry",      pk(4'b0000, 3'd2, 1'b0));
      expect_at(t + 28, "rev_entry_dt",   pk(4'b0000, 3'd2, 1'b0));
      expect_at(t + 29, "rev_gates_on",   pk(4'b0101, 3'd2, 1'b0));
      step(35);
      r = cyc;
      pwm_i = 1'b1;
      expect_at(r + 3, "rev_bl_off", pk(4'b0100, 3'd2, 1'b0));
      expect_at(r + 7, "rev_bh_on",  pk(4'b0110, 3'd2, 1'b0));
      step(10);

      // Illegal request: both directions while in DRIVE_REV.
      t = cyc;
      dir_fwd_i = 1'b1;
      expect_at(t + 2,  "both_held",       pk(4'b0110, 3'd2, 1'b0));
      expect_at(t + 3,  "both_coast",      pk(4'b0000, 3'd3, 1'b0));
      expect_at(t + 22, "both_coast_last", pk(4'b0000, 3'd3, 1'b0));
      expect_at(t + 23, "both_stop",       pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 24, "both_stay_stop1", pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 40, "both_stay_stop2", pk(4'b0000, 3'd0, 1'b0));
      step(42);

      // Back to forward (pwm high), then overcurrent.
      t = cyc;
      dir_rev_i = 1'b0;
      expect_at(t + 3, "fwd2_entry", pk(4'b0000, 3'd1, 1'b0));
      expect_at(t + 8, "fwd2_ah_on", pk(4'b1001, 3'd1, 1'b0));
      step(12);
      x = cyc;
      fault_i = 1'b1;
      expect_at(x + 2,  "fault_not_yet", pk(4'b1001, 3'd1, 1'b0));
      expect_at(x + 3,  "fault_entry",   pk(4'b0000, 3'd4, 1'b1));
      expect_at(x + 8,  "fault_clr_ign", pk(4'b0000, 3'd4, 1'b1));
      expect_at(x + 10, "fault_clr_ign2", pk(4'b0000, 3'd4, 1'b1));
      expect_at(x + 11, "fault_clr_ign3", pk(4'b0000, 3'd4, 1'b1));
      expect_at(x + 16, "fault_latched", pk(4'b0000, 3'd4, 1'b1));
      step(5);
      fault_clr_i = 1'b1;
      step(4);
      fault_clr_i = 1'b0;
      step(3);
      fault_i = 1'b0;
      step(6);
      y = cyc;
      fault_clr_i = 1'b1;
      expect_at(y + 2, "clr_pending", pk(4'b0000, 3'd4, 1'b1));
      expect_at(y + 3, "clr_stop",    pk(4'b0000, 3'd0, 1'b0));
      expect_at(y + 4, "clr_redrive", pk(4'b0000, 3'd1, 1'b0));
      expect_at(y + 9, "clr_ah_on",   pk(4'b1001, 3'd1, 1'b0));
      step(4);
      fault_clr_i = 1'b0;
      step(8);

      // Asynchronous reset while gate_ah_o is on.
      #2;
      reset_l = 1'b0;
      step(2);
      reset_l = 1'b1;
      t = cyc;
      expect_at(t,     "rst_rel0",  pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 1, "rst_rel1",  pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 2, "rst_rel2",  pk(4'b0000, 3'd0, 1'b0));
      expect_at(t + 3, "rst_redrive", pk(4'b0000, 3'd1, 1'b0));
      step(4);
      done_cyc  = cyc;
      stim_done = 1'b1;
   end

endmodule
